// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit:
// funct3 codes, FSM states and the fault rule.
package load_store_unit_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } lsu_state_e;

  function automatic logic lsu_fault(
    input logic       wr,
    input logic [2:0] f3,
    input logic [1:0] a
  );
    logic f;
    f = 1'b1;
    case (f3)
      F3_B:    f = 1'b0;
      F3_H:    f = a[0];
      F3_W:    f = (a != 2'b00);
      F3_BU:   f = wr;
      F3_HU:   f = wr | a[0];
      default: f = 1'b1;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/load_store_unit_lane_align.sv
// Lane extract/extend for loads and
// read-modify-write merge for sub-word stores.
module load_store_unit_lane_align
  import load_store_unit_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [2:0]  f3,
  input  logic [1:0]  k,
  output logic [31:0] load_data,
  output logic [31:0] store_data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  always_comb begin
    byte_s    = word[{k, 3'b000} +: 8];
    half_s    = k[1] ? word[31:16] : word[15:0];
    load_data = word;
    case (f3)
      F3_B:    load_data = {{24{byte_s[7]}}, byte_s};
      F3_H:    load_data = {{16{half_s[15]}}, half_s};
      F3_BU:   load_data = {24'b0, byte_s};
      F3_HU:   load_data = {16'b0, half_s};
      default: load_data = word;
    endcase
  end

  always_comb begin
    store_data = wdata;
    case (f3)
      F3_B: begin
        store_data = word;
        store_data[{k, 3'b000} +: 8] = wdata[7:0];
      end
      F3_H: begin
        store_data = word;
        store_data[{k[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: store_data = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Sub-word load/store engine between the memory
// stage and a word-wide RAM.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int RAM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_misaligned,
  output logic [31:0] ram_address,
  output logic [31:0] ram_data_in,
  output logic        ram_write_enable,
  input  logic [31:0] ram_data_out
);

  localparam int CW =
    (RAM_LATENCY > 1) ? $clog2(RAM_LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LAST =
    CW'(RAM_LATENCY - 1);

  lsu_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic [2:0]    f3_q, f3_d;
  logic          write_q, write_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   word_q, word_d;
  logic          fault_q, fault_d;

  logic [31:0] load_data;
  logic [31:0] store_data;

  load_store_unit_lane_align u_align (
    .word       (word_q),
    .wdata      (wdata_q),
    .f3         (f3_q),
    .k          (addr_q[1:0]),
    .load_data  (load_data),
    .store_data (store_data)
  );

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    addr_d           = addr_q;
    f3_d             = f3_q;
    write_d          = write_q;
    wdata_d          = wdata_q;
    word_d           = word_q;
    fault_d          = fault_q;
    req_ready        = 1'b0;
    resp_valid       = 1'b0;
    resp_rdata       = 32'b0;
    resp_misaligned  = 1'b0;
    ram_address      = 32'b0;
    ram_data_in      = 32'b0;
    ram_write_enable = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_d  = req_addr;
          f3_d    = req_funct3;
          write_d = req_write;
          wdata_d = req_wdata;
          cnt_d   = '0;
          fault_d = lsu_fault(req_write, req_funct3,
                              req_addr[1:0]);
          if (fault_d)
            state_d = S_DONE;
          else if (req_write && req_funct3 == F3_W)
            state_d = S_WRITE;
          else
            state_d = S_READ;
        end
      end
      S_READ: begin
        ram_address = {addr_q[31:2], 2'b00};
        if (cnt_q == CNT_LAST) begin
          word_d  = ram_data_out;
          state_d = write_q ? S_WRITE : S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WRITE: begin
        ram_address      = {addr_q[31:2], 2'b00};
        ram_write_enable = 1'b1;
        ram_data_in      = store_data;
        state_d          = S_DONE;
      end
      S_DONE: begin
        resp_valid      = 1'b1;
        resp_misaligned = fault_q;
        // stores and faults return zero data
        if (!write_q && !fault_q)
          resp_rdata = load_data;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      f3_q    <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      word_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      f3_q    <= f3_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      word_q  <= word_d;
      fault_q <= fault_d;
    end
  end

endmodule
